// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
//   Management-side driver for the GPIO configuration shift chain. Holds one
//   PAD_CTRL_BITS-wide word per GPIO in a local register file. On xfer_start
//   it shifts every word down the chain on a self-generated serial_clock.
//   It then pulses serial_load so that each control block latches its word.
//
// Ports
//   clk, resetn        core clock, asynchronous active-low reset
//   cfg_we/addr/wdata  register-file write; dropped while busy or out of range
//   cfg_rdata          combinational read of entry cfg_addr (0 if out of range)
//   cfg_wr_err         one-cycle pulse after a dropped write
//   xfer_start         start request (ignored while busy)
//   busy, done         transfer in progress / one-cycle end pulse
//   serial_clock/data  chain shift clock and data to block 0
//   serial_load        chain latch strobe
//   chain_return       serial_data_out of the last block (readback only)
//   chain_mismatch     readback error flag
//
// Build option
//   GPIO_LOADER_READBACK_EN : compare the returning chain image against a
//   shadow of the previously sent stream. When undefined, chain_mismatch is
//   tied to 0 and no shadow storage exists.

module gpio_serial_loader #(
  parameter int                       NUM_GPIO      = 19,
  parameter int                       PAD_CTRL_BITS = 13,
  parameter int                       CLK_DIV       = 2,
  parameter logic [PAD_CTRL_BITS-1:0] CFG_DEFAULT   = 13'h0403,
  localparam int                      AW            = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0] cfg_wdata,
  output logic [PAD_CTRL_BITS-1:0] cfg_rdata,
  output logic                     cfg_wr_err,
  input  logic                     xfer_start,
  output logic                     busy,
  output logic                     done,
  output logic                     serial_clock,
  output logic                     serial_data,
  output logic                     serial_load,
  input  logic                     chain_return,
  output logic                     chain_mismatch
);

  localparam int BW    = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;
  localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NBITS = NUM_GPIO * PAD_CTRL_BITS;

  typedef enum logic [2:0] {IDLE, SH_LO, SH_HI, LD_GAP, LD_HI, FIN} state_e;

  state_e                   state_q, state_d;
  // The global bit counter is kept as a word index plus a bit-in-word index.
  // This allows the register file to be addressed directly without dividing by
  // PAD_CTRL_BITS.
  logic [AW-1:0]            word_q, word_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic [PW-1:0]            ph_q, ph_d;
  logic                     ph_last;

  logic [PAD_CTRL_BITS-1:0] mem_q [NUM_GPIO];
  logic [PAD_CTRL_BITS-1:0] mem_d [NUM_GPIO];

  logic                     busy_q, done_q, wr_err_q;
  logic                     sclk_q, sdata_q, sload_q;
  logic                     in_range, wr_ok, shifting_d;

  assign in_range = (int'(cfg_addr) < NUM_GPIO);
  assign wr_ok    = cfg_we && !busy_q && in_range;

  // The write is folded into mem_d. A write that coincides with xfer_start is
  // therefore visible to the first shifted bit in the same edge.
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[cfg_addr] = cfg_wdata;
  end

  assign cfg_rdata = in_range ? mem_q[cfg_addr] : '0;

  // Next-state logic
  assign ph_last = (ph_q == PW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    unique case (state_q)
      IDLE: if (xfer_start) begin
        state_d = SH_LO;
        word_d  = AW'(NUM_GPIO - 1);
        bit_d   = BW'(PAD_CTRL_BITS - 1);
        ph_d    = '0;
      end
      SH_LO: if (ph_last) begin
        state_d = SH_HI;
        ph_d    = '0;
      end else ph_d = ph_q + PW'(1);
      SH_HI: if (ph_last) begin
        ph_d = '0;
        if (word_q == '0 && bit_q == '0) state_d = LD_GAP;
        else begin
          state_d = SH_LO;
          if (bit_q == '0) begin
            bit_d  = BW'(PAD_CTRL_BITS - 1);
            word_d = word_q - AW'(1);
          end else bit_d = bit_q - BW'(1);
        end
      end else ph_d = ph_q + PW'(1);
      LD_GAP: if (ph_last) begin
        state_d = LD_HI;
        ph_d    = '0;
      end else ph_d = ph_q + PW'(1);
      LD_HI: if (ph_last) begin
        state_d = FIN;
        ph_d    = '0;
      end else ph_d = ph_q + PW'(1);
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign shifting_d = (state_d == SH_LO) || (state_d == SH_HI);

  // All outputs are registered from the next state. Each output therefore
  // changes on the same edge as the state that owns it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      word_q   <= '0;
      bit_q    <= '0;
      ph_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sload_q  <= 1'b0;
      for (int i = 0; i < NUM_GPIO; i++) mem_q[i] <= CFG_DEFAULT;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      mem_q    <= mem_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == FIN);
      wr_err_q <= cfg_we && !wr_ok;
      sclk_q   <= (state_d == SH_HI);
      sload_q  <= (state_d == LD_HI);
      sdata_q  <= shifting_d ? mem_d[word_d][bit_d] : 1'b0;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_wr_err   = wr_err_q;
  assign serial_clock = sclk_q;
  assign serial_data  = sdata_q;
  assign serial_load  = sload_q;

`ifdef GPIO_LOADER_READBACK_EN
  // The chain holds the previous image. Its output is sampled once per bit,
  // while serial_clock is high. The shadow rotates the previously sent stream
  // out of its MSB and shifts the current bit into its LSB. After NBITS bits it
  // holds exactly the stream of this transfer.
  logic [NBITS-1:0] shadow_q;
  logic             mism_q;
  logic             sample;

  assign sample = (state_q == SH_HI) && (ph_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q <= '0;
      mism_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && xfer_start)                    mism_q <= 1'b0;
      else if (sample && (chain_return != shadow_q[NBITS-1])) mism_q <= 1'b1;
      if (sample) shadow_q <= {shadow_q[NBITS-2:0], sdata_q};
    end
  end

  assign chain_mismatch = mism_q;
`else
  logic unused_chain_return;
  assign unused_chain_return = chain_return;
  assign chain_mismatch      = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader.
// dut  : default parameters (19 x 13 bits, CLK_DIV=2) with a 247-bit chain model
// dut2 : NUM_GPIO=2, CLK_DIV=1 with a 26-bit chain model
// The chain model shifts on the rising edge of serial_clock and updates its
// return output on the falling edge, in the same way as a padframe control block.
module tb_gpio_serial_loader;
  localparam int P = 13, N = 19, NB = N * P, N2 = 2, NB2 = N2 * P;

  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // ---- dut (defaults)
  logic         cfg_we = 1'b0, xfer_start = 1'b0;
  logic [4:0]   cfg_addr = '0;
  logic [P-1:0] cfg_wdata = '0, cfg_rdata;
  logic         cfg_wr_err, busy, done, sclk, sdata, sload, ret, mism;

  gpio_serial_loader dut (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_wr_err(cfg_wr_err),
    .xfer_start(xfer_start), .busy(busy), .done(done), .serial_clock(sclk),
    .serial_data(sdata), .serial_load(sload), .chain_return(ret),
    .chain_mismatch(mism)
  );

  // ---- dut2 (2 GPIO, CLK_DIV=1)
  logic         cfg_we2 = 1'b0, xfer_start2 = 1'b0;
  logic [0:0]   cfg_addr2 = '0;
  logic [P-1:0] cfg_wdata2 = '0, cfg_rdata2;
  logic         cfg_wr_err2, busy2, done2, sclk2, sdata2, sload2, ret2, mism2;

  gpio_serial_loader #(.NUM_GPIO(N2), .CLK_DIV(1)) dut2 (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we2), .cfg_addr(cfg_addr2),
    .cfg_wdata(cfg_wdata2), .cfg_rdata(cfg_rdata2), .cfg_wr_err(cfg_wr_err2),
    .xfer_start(xfer_start2), .busy(busy2), .done(done2), .serial_clock(sclk2),
    .serial_data(sdata2), .serial_load(sload2), .chain_return(ret2),
    .chain_mismatch(mism2)
  );

  // ---- chain models
  logic [NB-1:0]  sr = '0, flip = '0;
  logic [NB2-1:0] sr2 = '0;
  logic [NB-1:0]  sr_f;
  assign sr_f = sr ^ flip;
  initial ret = 1'b0;
  initial ret2 = 1'b0;
  always @(posedge sclk)  sr  <= {sr_f[NB-2:0], sdata};
  always @(negedge sclk)  ret <= sr_f[NB-1];
  always @(posedge sclk2) sr2 <= {sr2[NB2-2:0], sdata2};
  always @(negedge sclk2) ret2 <= sr2[NB2-1];

  // ---- event monitors
  int   rises = 0, rises2 = 0, load_edges = 0, load_cyc = 0, dones = 0, viol2 = 0;
  logic prev2 = 1'b0;
  always @(posedge sclk)  rises <= rises + 1;
  always @(posedge sclk2) rises2 <= rises2 + 1;
  always @(posedge sload) load_edges <= load_edges + 1;
  always @(negedge clk) begin
    if (sload) load_cyc <= load_cyc + 1;
    if (done)  dones <= dones + 1;
    if ((sdata2 !== prev2) && sclk2) viol2 <= viol2 + 1;
    prev2 <= sdata2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) xfer_start2 = 1'b1; else xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0; xfer_start2 = 1'b0; cfg_we = 1'b0; cfg_we2 = 1'b0;
  endtask

  // The returned cyc is the cycle index in which done was seen. The accept
  // cycle is cycle 0. On a timeout, cyc equals the budget.
  task automatic wait_done(input bit sel, input int budget, output int cyc);
    cyc = 1;
    while (((sel ? done2 : done) !== 1'b1) && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [P-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  int cyc, r0, l0, lc0, d0, k;

  initial begin
    // 1: reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_sclk", sclk, 0); chk("rst_sdata", sdata, 0);
    chk("rst_sload", sload, 0); chk("rst_err", cfg_wr_err, 0);
    chk("rst_mism", mism, 0);
    resetn = 1'b1;
    tick();
    for (int a = 0; a < N; a++) begin
      cfg_addr = 5'(a); #1;
      chk($sformatf("rst_rd%0d", a), cfg_rdata, 13'h0403);
    end
    cfg_addr = 5'd20; #1;
    chk("rd_oor", cfg_rdata, 0);

    // 2: write 0, write 18 together with start, full transfer
    wr(5'd0, 13'h1FFF);
    cfg_we = 1'b1; cfg_addr = 5'd18; cfg_wdata = 13'h0001;
    r0 = rises; l0 = load_edges; lc0 = load_cyc;
    pulse_start(0);
    chk("t2_busy", busy, 1);
    chk("t2_sclk_lo", sclk, 0);
    wait_done(0, 1200, cyc);
    chk("t2_done_cyc", cyc, 993);
    chk("t2_rises", rises - r0, 247);
    chk("t2_load_edges", load_edges - l0, 1);
    chk("t2_load_width", load_cyc - lc0, 2);
    chk("t2_blk0", sr[0 +: P], 13'h1FFF);
    chk("t2_blk18", sr[18*P +: P], 13'h0001);
    for (int b = 1; b < 18; b++) chk($sformatf("t2_blk%0d", b), sr[b*P +: P], 13'h0403);
    chk("t2_busy_fin", busy, 1);
    tick();
    chk("t2_busy_after", busy, 0);
    chk("t2_done_after", done, 0);
    chk("t2_mism", mism, 0);

    // 3: write and start while busy
    pulse_start(0);
    repeat (10) tick();
    cfg_we = 1'b1; cfg_addr = 5'd5; cfg_wdata = 13'h1555;
    tick();
    cfg_we = 1'b0;
    chk("t3_err_pulse", cfg_wr_err, 1);
    tick();
    chk("t3_err_clr", cfg_wr_err, 0);
    xfer_start = 1'b1; tick(); xfer_start = 1'b0;
    d0 = dones;
    wait_done(0, 1200, cyc);
    chk("t3_done_seen", done, 1);
    repeat (20) tick();
    chk("t3_single_done", dones - d0, 1);
    chk("t3_idle", busy, 0);
    cfg_addr = 5'd5; #1;
    chk("t3_e5_kept", cfg_rdata, 13'h0403);
    wr(5'd25, 13'h0777);
    chk("t3_oor_err", cfg_wr_err, 1);
    cfg_addr = 5'd25; #1;
    chk("t3_oor_rd", cfg_rdata, 0);

    // 4: reset mid-transfer at bit 100
    r0 = rises; l0 = load_edges; d0 = dones;
    pulse_start(0);
    k = 0;
    while ((rises - r0) < 100 && k < 2000) begin tick(); k++; end
    chk("t4_reach100", rises - r0, 100);
    resetn = 1'b0; #1;
    chk("t4_busy", busy, 0); chk("t4_sclk", sclk, 0);
    chk("t4_sdata", sdata, 0); chk("t4_sload", sload, 0);
    tick();
    chk("t4_busy_edge", busy, 0); chk("t4_sclk_edge", sclk, 0);
    chk("t4_no_load", load_edges - l0, 0);
    chk("t4_no_done", dones - d0, 0);
    resetn = 1'b1;
    tick();
    cfg_addr = 5'd0; #1;
    chk("t4_e0_reset", cfg_rdata, 13'h0403);
    pulse_start(0);
    wait_done(0, 1200, cyc);
    chk("t4_done_cyc", cyc, 993);
    chk("t4_blk0", sr[0 +: P], 13'h0403);
    chk("t4_blk9", sr[9*P +: P], 13'h0403);
    chk("t4_blk18", sr[18*P +: P], 13'h0403);
    tick();

    // 5: small chain, CLK_DIV=1
    cfg_we2 = 1'b1; cfg_addr2 = 1'b1; cfg_wdata2 = 13'h0AAA;
    tick();
    cfg_we2 = 1'b0;
    r0 = rises2;
    pulse_start(1);
    wait_done(1, 200, cyc);
    chk("t5_done_cyc", cyc, 55);
    chk("t5_rises", rises2 - r0, 26);
    chk("t5_blk0", sr2[0 +: P], 13'h0403);
    chk("t5_blk1", sr2[P +: P], 13'h0AAA);
    chk("t5_data_stable", viol2, 0);
    tick();

`ifdef GPIO_LOADER_READBACK_EN
    // 6: readback
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    wr(5'd3, 13'h1234);
    pulse_start(0); wait_done(0, 1200, cyc); tick();
    pulse_start(0); wait_done(0, 1200, cyc); tick();
    chk("t6_same_mism", mism, 0);
    flip[100] = 1'b1;
    pulse_start(0); wait_done(0, 1200, cyc); tick();
    chk("t6_flip_mism", mism, 1);
    flip = '0;
    pulse_start(0);
    chk("t6_clear_on_start", mism, 0);
    wait_done(0, 1200, cyc);
`else
    chk("t6_mism_tied", mism, 0);
    chk("t6_mism2_tied", mism2, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_serial_loader.md
Name: gpio_serial_loader

Overview:
- Drives the GPIO configuration shift chain from the management side.
- Holds one PAD_CTRL_BITS-wide config word per GPIO in a local register file. On request, it shifts all words serially down the chain with its own generated serial_clock, then pulses serial_load so every control block latches its word.
- Sits in housekeeping, clocked by the core clock, feeding the first gpio_control_block of the padframe chain.

Parameters:
- NUM_GPIO, 19, number of control blocks in the chain; index 0 is nearest the loader.
- PAD_CTRL_BITS, 13, config bits per block.
- CLK_DIV, 2, clk cycles per serial_clock half-period; must be >= 1.
- CFG_DEFAULT, 13'h0403, reset value of every register-file entry.

Ports:
- clk  input  1  core clock; all state is on posedge.
- resetn  input  1  asynchronous active-low reset.
- cfg_we  input  1  register-file write strobe.
- cfg_addr  input  $clog2(NUM_GPIO)  entry select for write and read.
- cfg_wdata  input  PAD_CTRL_BITS  write data.
- cfg_rdata  output  PAD_CTRL_BITS  combinational read of entry cfg_addr; 0 if cfg_addr >= NUM_GPIO.
- cfg_wr_err  output  1  one-cycle pulse when a write is dropped.
- xfer_start  input  1  start request pulse.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse at transfer end.
- serial_clock  output  1  chain shift clock.
- serial_data  output  1  chain data to the first block.
- serial_load  output  1  chain latch strobe.
- chain_return  input  1  serial_data_out of the last block (used only with the optional feature).
- chain_mismatch  output  1  readback error flag (0 without the optional feature).

Behaviour:
- Reset values:
  - All register-file entries = CFG_DEFAULT.
  - busy, done, cfg_wr_err, serial_clock, serial_data, serial_load, chain_mismatch = 0.
  - FSM = IDLE.
- Register-file writes:
  - A write takes effect when cfg_we=1, busy=0 and cfg_addr < NUM_GPIO.
  - cfg_we with busy=1 or cfg_addr out of range: write dropped, cfg_wr_err=1 next cycle.
- FSM states: IDLE, SH_LO, SH_HI, LD_GAP, LD_HI, FIN.
- IDLE:
  - xfer_start=1 moves to SH_LO with bit counter = NUM_GPIO*PAD_CTRL_BITS-1 and phase counter = 0.
  - A simultaneous cfg_we is applied first, so the new word is shifted.
- Bit order:
  - Entry NUM_GPIO-1 goes first, entry 0 last.
  - Within an entry, MSB first.
  - This leaves word k in block k.
- SH_LO:
  - serial_clock=0; serial_data holds the current bit for the whole state.
  - After CLK_DIV cycles, go to SH_HI.
- SH_HI:
  - serial_clock=1 for CLK_DIV cycles; serial_data is stable across the rising edge.
  - If bits remain: decrement the bit counter and go to SH_LO; the next bit is driven in the same cycle serial_clock falls.
  - If no bits remain: go to LD_GAP.
- LD_GAP:
  - serial_clock=0, serial_data=0 for CLK_DIV cycles, then go to LD_HI.
- LD_HI:
  - serial_load=1 for CLK_DIV cycles, then go to FIN.
- FIN:
  - serial_load=0, done=1 for one cycle, busy=0 next cycle, return to IDLE.
- busy:
  - Is 1 from the cycle after xfer_start is accepted through the FIN cycle.
- Timing:
  - All outputs are registered.
  - xfer_start accepted at cycle 0 gives done at cycle 1 + 2*CLK_DIV*(NUM_GPIO*PAD_CTRL_BITS + 1).
  - With the defaults (19 GPIO, 13 bits, CLK_DIV=2) that is cycle 993.
- xfer_start while busy: ignored, not queued.
- resetn asserted mid-transfer: immediately return to reset values; the partial shift is abandoned with no serial_load pulse.

Optional Feature:
- Macro: GPIO_LOADER_READBACK_EN.
- Defined:
  - chain_return is sampled on the clk cycle in which serial_clock rises (first SH_HI cycle).
  - The samples are the previous chain image, farthest block MSB first.
  - Each sample is compared against a shadow of the bit stream sent by the previous transfer; after reset the shadow is all zeros.
  - Any mismatch sets chain_mismatch, which stays set until the next xfer_start accept or reset.
  - The shadow is updated with the stream sent during the current transfer.
- Undefined: chain_return is ignored, chain_mismatch is tied to 0, and no shadow storage exists.

Test Plan:
1. Reset, then read all entries -> every cfg_rdata = 13'h0403; serial_clock/serial_data/serial_load = 0.
2. Write entry 0 = 13'h1FFF and entry 18 = 13'h0001, xfer_start with a 19-block chain model attached -> done at cycle 993; model block 0 = 13'h1FFF, block 18 = 13'h0001, others 13'h0403; exactly 247 rising serial_clock edges; one serial_load pulse 2 cycles wide.
3. cfg_we during busy to entry 5 -> cfg_wr_err pulses, entry 5 unchanged; xfer_start during busy -> no second transfer, single done.
4. Assert resetn at bit 100 of a transfer -> all outputs 0 on the next clk edge, no serial_load; a fresh transfer afterwards completes normally.
5. CLK_DIV=1, NUM_GPIO=2 -> done at cycle 1 + 2*27 = 55; data only changes while serial_clock=0.
6. With GPIO_LOADER_READBACK_EN: two identical transfers -> chain_mismatch=0; then force one model bit flip between transfers -> chain_mismatch=1 after the third transfer, cleared at the next xfer_start accept.
